// File: rtl/epp_pkg.sv
// Shared types and constants for the EPP slave bridge and the register map behind it.
package epp_pkg;

  localparam int unsigned EPP_DW = 8;

  typedef logic [EPP_DW-1:0] epp_byte_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_WR  = 3'd1,
    ADDR_RD  = 3'd2,
    DATA_WR  = 3'd3,
    DATA_RD  = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6
  } epp_state_e;

  localparam epp_byte_t ADDR_LED = 8'h01;

  // Address register post-increment; 8'hFF wraps to 8'h00 by width.
  function automatic epp_byte_t addr_next(input epp_byte_t a);
    return a + epp_byte_t'(1);
  endfunction

endpackage

// File: rtl/epp_reg_bridge_if.sv
// Internal register bus between the EPP bridge (master) and peripheral register slaves.
interface epp_reg_bridge_if;
  import epp_pkg::*;

  epp_byte_t reg_addr;
  epp_byte_t reg_wdata;
  logic      reg_we;
  logic      reg_re;
  epp_byte_t reg_rdata;
  logic      reg_ack;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/epp_sync.sv
// Multi-bit flop-chain synchroniser; resets to all-ones so idle-high strobes read as inactive.
module epp_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  localparam int unsigned NS = (STAGES < 2) ? 2 : STAGES;

  logic [NS-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[NS-2:0], d_i};
    end
  end

  assign q_o = sync_q[NS-1];

endmodule

// File: rtl/epp_reg_bridge.sv
// Digilent EPP slave: synchronises host strobes, holds the address register and maps
// data cycles onto single-cycle register-bus requests with ack and timeout.
module epp_reg_bridge
  import epp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter bit          AUTO_INC     = 1'b0,
  parameter epp_byte_t   TIMEOUT_DATA = 8'hFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             EppAstb,
  input  logic             EppDstb,
  input  logic             EppWr,
  output logic             EppWait,
  input  epp_byte_t        EppDB_i,
  output epp_byte_t        EppDB_o,
  output logic             EppDB_oe,
  epp_reg_bridge_if.master bus,
  output logic             timeout_err
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned TO     = (ACK_TIMEOUT < 1) ? 1 : ACK_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO - 1);

  logic astb_s, dstb_s, wr_s;

  epp_sync #(
    .WIDTH  (3),
    .STAGES (STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   ({EppAstb, EppDstb, EppWr}),
    .q_o   ({astb_s, dstb_s, wr_s})
  );

  epp_state_e       state_q,   state_d;
  epp_byte_t        addr_q,    addr_d;
  epp_byte_t        wdata_q,   wdata_d;
  epp_byte_t        dbo_q,     dbo_d;
  epp_byte_t        sample_q,  sample_d;
  logic             oe_q,      oe_d;
  logic             wait_q,    wait_d;
  logic             we_q,      we_d;
  logic             re_q,      re_d;
  logic             terr_q,    terr_d;
  logic             is_data_q, is_data_d;
  logic             is_read_q, is_read_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      dbo_q     <= '0;
      sample_q  <= '0;
      oe_q      <= 1'b0;
      wait_q    <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      terr_q    <= 1'b0;
      is_data_q <= 1'b0;
      is_read_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dbo_q     <= dbo_d;
      sample_q  <= sample_d;
      oe_q      <= oe_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      re_q      <= re_d;
      terr_q    <= terr_d;
      is_data_q <= is_data_d;
      is_read_q <= is_read_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dbo_d     = dbo_q;
    sample_d  = sample_q;
    oe_d      = oe_q;
    wait_d    = wait_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    terr_d    = terr_q;
    is_data_d = is_data_q;
    is_read_d = is_read_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      // Address strobe wins when both strobes are seen low together.
      IDLE: begin
        if (!astb_s) begin
          sample_d  = EppDB_i;
          is_data_d = 1'b0;
          is_read_d = wr_s;
          state_d   = wr_s ? ADDR_RD : ADDR_WR;
        end else if (!dstb_s) begin
          sample_d  = EppDB_i;
          is_data_d = 1'b1;
          is_read_d = wr_s;
          state_d   = wr_s ? DATA_RD : DATA_WR;
        end
      end

      ADDR_WR: begin
        addr_d  = sample_q;
        wait_d  = 1'b1;
        state_d = DONE;
      end

      ADDR_RD: begin
        dbo_d   = addr_q;
        oe_d    = 1'b1;
        wait_d  = 1'b1;
        state_d = DONE;
      end

      DATA_WR: begin
        wdata_d = sample_q;
        we_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end

      DATA_RD: begin
        re_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end

      // Ack is checked before the timeout so a last-cycle ack still counts.
      WAIT_ACK: begin
        if (bus.reg_ack) begin
          if (is_read_q) begin
            dbo_d = bus.reg_rdata;
            oe_d  = 1'b1;
          end
          wait_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (is_read_q) begin
            dbo_d = TIMEOUT_DATA;
            oe_d  = 1'b1;
          end
          terr_d  = 1'b1;
          wait_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (is_data_q ? dstb_s : astb_s) begin
          wait_d  = 1'b0;
          oe_d    = 1'b0;
          state_d = IDLE;
          if (AUTO_INC && is_data_q) begin
            addr_d = addr_next(addr_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign EppWait       = wait_q;
  assign EppDB_o       = dbo_q;
  assign EppDB_oe      = oe_q;
  assign timeout_err   = terr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;

endmodule

// File: doc/epp_reg_bridge.md
Name: epp_reg_bridge

Overview:
- Slave side of the Digilent Adept2 EPP port, instantiated inside `system` directly behind the EppAstb/EppDstb/EppWr/EppWait/EppDB pins.
- Synchronises the asynchronous host strobes and decodes address and data cycles.
- Holds the 8-bit EPP address register and turns data cycles into single-cycle read/write requests on an internal register bus with ack.
- Data-cycle results (Led and other peripheral registers) come from the register-bus slaves downstream.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on EppAstb/EppDstb/EppWr (min 2).
- ACK_TIMEOUT, 16, clk cycles to wait for reg_ack before forcing completion.
- AUTO_INC, 0, 1 = address register increments after every completed data cycle.
- TIMEOUT_DATA, 8'hFF, read data returned on timeout.

Ports:
- clk  in  1  system clock (100 MHz on Nexys3).
- reset_n  in  1  asynchronous active-low reset.
- EppAstb  in  1  host address strobe, active low, asynchronous.
- EppDstb  in  1  host data strobe, active low, asynchronous.
- EppWr  in  1  host direction: 0 = host writes, 1 = host reads.
- EppWait  out  1  1 = cycle complete; held until the strobe is released.
- EppDB_i  in  8  data from pad.
- EppDB_o  out  8  data to pad.
- EppDB_oe  out  1  pad output enable; the top drives EppDB = oe ? EppDB_o : 8'hzz.
- reg_addr  out  8  register bus address (= address register).
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write request.
- reg_re  out  1  one-cycle read request.
- reg_rdata  in  8  read data, valid when reg_ack = 1.
- reg_ack  in  1  slave completion; may arrive the cycle after the request or later.
- timeout_err  out  1  sticky; set on ack timeout; cleared only by reset.

Behaviour:
- Reset (async, reset_n = 0):
  - EppWait, EppDB_oe, reg_we, reg_re and timeout_err are 0.
  - EppDB_o, reg_addr and reg_wdata are 8'h00.
  - FSM goes to IDLE; synchroniser flops are set to 1 (strobes idle high).
  - Reset mid-cycle abandons the cycle with no bus request issued afterwards.
- Synchronisation:
  - EppAstb, EppDstb and EppWr each pass through SYNC_STAGES flops.
  - EppDB_i is sampled only in the cycle the FSM leaves IDLE (the host holds data stable from before the strobe falls).
- FSM states: IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, WAIT_ACK, DONE.
- IDLE:
  - Synced Astb = 0 → ADDR_WR if synced Wr = 0, else ADDR_RD.
  - Otherwise synced Dstb = 0 → DATA_WR if Wr = 0, else DATA_RD.
  - Both strobes low: Astb has priority.
- ADDR_WR: address register <= sampled EppDB_i; → DONE.
- ADDR_RD: EppDB_o <= address register; EppDB_oe = 1; → DONE.
- DATA_WR: reg_wdata <= sample; reg_we pulses 1 cycle; → WAIT_ACK.
- DATA_RD: reg_re pulses 1 cycle; → WAIT_ACK.
- WAIT_ACK:
  - On reg_ack: for a read, EppDB_o <= reg_rdata and EppDB_oe = 1; → DONE.
  - If no ack after ACK_TIMEOUT cycles: for a read, EppDB_o <= TIMEOUT_DATA; timeout_err <= 1; → DONE.
  - An ack arriving in the same cycle the count expires counts as an ack.
- DONE:
  - EppWait = 1; EppDB_oe is held for read cycles.
  - When the synced strobe of the active cycle returns to 1: EppWait <= 0, EppDB_oe <= 0, → IDLE.
  - If AUTO_INC = 1 and the cycle was a data cycle, the address register increments at this point, 8'hFF wraps to 8'h00.
- Host abort:
  - A strobe released while in WAIT_ACK is not honoured early: the bridge finishes the bus transaction.
  - DONE then sees the strobe high and returns to IDLE one cycle later; EppWait pulses for 1 clk.
- Latency: strobe fall at the pin → EppWait rise = SYNC_STAGES + 2 clk for address cycles; data cycles add ack latency.
- Only one outstanding bus request at a time; reg_we and reg_re are never high together.

Decomposition:
- Shared package epp_pkg holds:
  - the FSM state enum;
  - the EPP bus width constant (8);
  - the ADDR_LED = 8'h01 register map constants used by `system`.
- One sub-module, epp_sync: a parameterised multi-bit synchroniser that resets to all-ones.
  - Instantiated once for {EppAstb, EppDstb, EppWr}.

Test Plan:
- Address write then read: Wr = 0, DB = 8'h01, Astb low → EppWait = 1 within 4 clk; reg_addr = 8'h01. Then Wr = 1, Astb low → EppDB = 8'h01, oe = 1 until Astb high.
- Data write: addr 8'h01, Wr = 0, DB = 8'hAA, Dstb low → one reg_we pulse with reg_addr = 01, reg_wdata = AA. Slave acks after 3 clk → EppWait = 1; strobe high → EppWait = 0.
- Data read: model slave returns 8'hAA with a 1-clk ack → EppDB = 8'hAA while EppWait = 1; oe = 0 within 3 clk of Dstb high.
- Timeout: slave never acks on a read → after 16 clk EppDB = 8'hFF, timeout_err = 1, no second reg_re.
- AUTO_INC = 1: addr 8'hFE, two data writes → reg_addr sequence FE, FF; a subsequent read is issued at 8'h00.
- Reset: reset_n low during WAIT_ACK → all outputs at reset values immediately; Astb and Dstb low together after reset → treated as an address cycle.
